fm_read_encoder: RTL and testbench



---
 rtl/fm_read_encoder_if.sv | 27 ++
 rtl/fm_read_encoder.sv | 204 ++++++++++++++++++++
 tb/tb_fm_read_encoder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_read_encoder_if.sv
// Word-input handshake bundle for the FM read encoder.
// Latency: none (wires only).
// Backpressure: din_ready low while the encoder's holding buffer is occupied.
//
// Signals:
//   din        producer -> encoder   data word
//   din_valid  producer -> encoder   din carries a word
//   din_ready  encoder  -> producer  holding buffer empty, word will be taken
interface fm_read_encoder_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/fm_read_encoder.sv
// Hawk read-side FM transmitter: clock pulse every cell, extra mid-cell pulse for a 1.
// Latency: first clock pulse one hf_clk after en is sampled in IDLE; output registered.
// Backpressure: one-word holding buffer; an empty buffer at a word load sends zeros and sets underrun.
//
// Ports:
//   i_hf_clk           high-frequency clock
//   i_rst_n            asynchronous active-low reset, aborts a sector at once
//   i_en               level request: starts a sector, low ends it at the next word boundary
//   s_in               word input handshake (din / din_valid / din_ready)
//   o_dsk_rd_data_clk  combined clock/data pulse stream
//   o_busy             a sector is in progress (registered)
//   o_underrun         sticky: a word was needed but the holding buffer was empty
module fm_read_encoder #(
  parameter int CELL_TICKS    = 20,  // 8..255
  parameter int DATA_OFFSET   = 10,  // > PULSE_TICKS
  parameter int PULSE_TICKS   = 2,   // DATA_OFFSET + PULSE_TICKS < CELL_TICKS
  parameter int PREAMBLE_BITS = 32,  // >= 1
  parameter int WORD_WIDTH    = 8
) (
  input  logic                i_hf_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  fm_read_encoder_if.slave    s_in,
  output logic                o_dsk_rd_data_clk,
  output logic                o_busy,
  output logic                o_underrun
);

  // bit_cnt counts preamble cells as well as data bits, so size it for the larger.
  localparam int BCW = $clog2((PREAMBLE_BITS > WORD_WIDTH) ? PREAMBLE_BITS : WORD_WIDTH) + 1;

  localparam logic [7:0]     CELL_LAST  = 8'(CELL_TICKS - 1);
  localparam logic [7:0]     PULSE_END  = 8'(PULSE_TICKS);
  localparam logic [7:0]     DATA_START = 8'(DATA_OFFSET);
  localparam logic [7:0]     DATA_END   = 8'(DATA_OFFSET + PULSE_TICKS);
  localparam logic [BCW-1:0] PRE_LAST   = BCW'(PREAMBLE_BITS - 1);
  localparam logic [BCW-1:0] WORD_LAST  = BCW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_POST     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_cell_cnt;
  logic [7:0]            w_cell_cnt_nxt;
  logic [BCW-1:0]        r_bit_cnt;
  logic [BCW-1:0]        w_bit_cnt_nxt;
  logic [WORD_WIDTH-1:0] r_shifter;
  logic [WORD_WIDTH-1:0] w_shifter_nxt;
  logic [WORD_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic                  w_hold_full_nxt;
  logic                  r_underrun;
  logic                  w_underrun_nxt;
  logic                  r_dsk;
  logic                  r_busy;

  logic                  w_boundary;
  logic                  w_load;
  logic                  w_discard;
  logic                  w_take;
  logic                  w_cur_bit;
  logic                  w_pulse;

  // Holding buffer handshake
  assign s_in.din_ready = ~r_hold_full;
  assign w_take         = s_in.din_valid & ~r_hold_full;

  assign w_boundary = (r_cell_cnt == CELL_LAST);

  // Preamble and post cells always carry 0; only DATA exposes the shifter MSB.
  assign w_cur_bit = (r_state == S_DATA) ? r_shifter[WORD_WIDTH-1] : 1'b0;

  assign w_pulse = (r_state != S_IDLE) &&
                   ((r_cell_cnt < PULSE_END) ||
                    (w_cur_bit && (r_cell_cnt >= DATA_START) && (r_cell_cnt < DATA_END)));

  // Next-state / datapath
  always_comb begin
    w_state_nxt    = r_state;
    w_cell_cnt_nxt = r_cell_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shifter_nxt  = r_shifter;
    w_underrun_nxt = r_underrun;
    w_load         = 1'b0;
    w_discard      = 1'b0;

    if (r_state != S_IDLE) begin
      w_cell_cnt_nxt = w_boundary ? 8'd0 : (r_cell_cnt + 8'd1);
    end

    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_state_nxt    = S_PREAMBLE;
          w_cell_cnt_nxt = 8'd0;
          w_bit_cnt_nxt  = '0;
          w_underrun_nxt = 1'b0;
        end
      end

      S_PREAMBLE: begin
        if (w_boundary) begin
          if (!i_en) begin
            // Truncated preamble: no data was promised, so no post cell either.
            w_state_nxt = S_IDLE;
          end else if (r_bit_cnt == PRE_LAST) begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = '0;
            w_load        = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (w_boundary) begin
          w_shifter_nxt = r_shifter << 1;
          if (r_bit_cnt == WORD_LAST) begin
            w_bit_cnt_nxt = '0;
            if (i_en) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = S_POST;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end

      S_POST: begin
        // The trailing clock-only cell lets the far-end separator commit the last bit.
        if (w_boundary) begin
          w_state_nxt = S_IDLE;
          w_discard   = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Word load overrides the shift. An empty buffer sends a zero word rather than stalling,
    // because the drive timing cannot pause mid-sector.
    if (w_load) begin
      if (r_hold_full) begin
        w_shifter_nxt = r_hold;
      end else begin
        w_shifter_nxt  = '0;
        w_underrun_nxt = 1'b1;
      end
    end
  end

  // A word accepted in the same cycle as a load/discard is kept: the handshake completed.
  always_comb begin
    w_hold_full_nxt = r_hold_full;
    if ((w_load && r_hold_full) || w_discard) begin
      w_hold_full_nxt = 1'b0;
    end
    if (w_take) begin
      w_hold_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_hf_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cell_cnt  <= 8'd0;
      r_bit_cnt   <= '0;
      r_shifter   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_underrun  <= 1'b0;
      r_dsk       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cell_cnt  <= w_cell_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shifter   <= w_shifter_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_underrun  <= w_underrun_nxt;
      if (w_take) begin
        r_hold <= s_in.din;
      end
      // Registered so the line never glitches on counter decode.
      r_dsk  <= w_pulse;
      r_busy <= (r_state != S_IDLE);
    end
  end

  assign o_dsk_rd_data_clk = r_dsk;
  assign o_busy            = r_busy;
  assign o_underrun        = r_underrun;

endmodule

// File: tb/tb_fm_read_encoder.sv
// Bench for fm_read_encoder: directed sectors checked cycle by cycle against a cell-level model.
// Latency: n/a.
// Backpressure: word feeder honours din_ready.
module tb_fm_read_encoder;
  localparam int CELL = 20;
  localparam int OFF  = 10;
  localparam int PW   = 2;
  localparam int PRE  = 32;
  localparam int WW   = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic dsk;
  logic busy;
  logic underrun;

  fm_read_encoder_if #(.WORD_WIDTH(WW)) bus ();

  fm_read_encoder #(
    .CELL_TICKS   (CELL),
    .DATA_OFFSET  (OFF),
    .PULSE_TICKS  (PW),
    .PREAMBLE_BITS(PRE),
    .WORD_WIDTH   (WW)
  ) dut (
    .i_hf_clk         (clk),
    .i_rst_n          (rst_n),
    .i_en             (en),
    .s_in             (bus),
    .o_dsk_rd_data_clk(dsk),
    .o_busy           (busy),
    .o_underrun       (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected {dsk, busy} per negedge, produced by the model
  logic [1:0] exp_q[$];
  logic [7:0] feed_q[$];
  logic [7:0] sector_words[$];

  // Event counters, read by snapshot/difference
  int pulse_cnt = 0;
  int busy_cnt  = 0;
  int rdy_rise  = 0;
  int rdy_fall  = 0;

  function automatic logic pulse_at(input logic b, input int t);
    return (t < PW) || (b && (t >= OFF) && (t < OFF + PW));
  endfunction

  // Compare process
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stream{dsk,busy}", {30'd0, dsk, busy}, {30'd0, e});
      end
    end
  end

  // Monitor
  initial begin
    logic dsk_prev;
    logic rdy_prev;
    dsk_prev = 1'b0;
    rdy_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (dsk && !dsk_prev) pulse_cnt++;
      if (busy) busy_cnt++;
      if (bus.din_ready && !rdy_prev) rdy_rise++;
      if (!bus.din_ready && rdy_prev) rdy_fall++;
      dsk_prev = dsk;
      rdy_prev = bus.din_ready;
    end
  end

  // Word feeder: handshake decided on the negedge sample, applied after the next posedge
  initial begin
    logic fire;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    forever begin
      @(negedge clk);
      fire = bus.din_valid && bus.din_ready && rst_n;
      @(posedge clk);
      #1;
      if (fire && feed_q.size() > 0) void'(feed_q.pop_front());
      if (feed_q.size() > 0) begin
        bus.din_valid = 1'b1;
        bus.din       = feed_q[0];
      end else begin
        bus.din_valid = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  task automatic wait_captured();
    int g;
    g = 0;
    while (bus.din_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("din_ready_after_capture", {31'd0, bus.din_ready}, 32'd0);
  endtask

  task automatic run_sector(input int n_pre, input bit post, input int drop_cell);
    logic cells[$];
    int   g;
    cells = {};
    for (int i = 0; i < n_pre; i++) cells.push_back(1'b0);
    foreach (sector_words[w])
      for (int b = WW - 1; b >= 0; b--) cells.push_back(sector_words[w][b]);
    if (post) cells.push_back(1'b0);

    @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("underrun_clear_on_start", {31'd0, underrun}, 32'd0);
    exp_q.push_back(2'b00);
    foreach (cells[c])
      for (int t = 0; t < CELL; t++) exp_q.push_back({pulse_at(cells[c], t), 1'b1});
    repeat (4) exp_q.push_back(2'b00);

    repeat (drop_cell * CELL + 4) @(posedge clk);
    #1;
    en = 1'b0;

    g = 0;
    while (exp_q.size() > 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("sector_drained", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    int b0;
    int rr0;
    int rf0;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_din_ready", {31'd0, bus.din_ready}, 32'd1);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_dsk", {31'd0, dsk}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_din_ready", {31'd0, bus.din_ready}, 32'd1);
      chk("idle_underrun", {31'd0, underrun}, 32'd0);
    end

    // Pre-loaded 0xA5, en dropped during the first word: 41 cells
    feed_q.push_back(8'hA5);
    wait_captured();
    sector_words = {8'hA5};
    p0 = pulse_cnt; b0 = busy_cnt;
    run_sector(PRE, 1'b1, 35);
    chk("a5_pulses", pulse_cnt - p0, 45);
    chk("a5_busy_cycles", busy_cnt - b0, 820);
    chk("a5_underrun", {31'd0, underrun}, 32'd0);
    chk("a5_din_ready_end", {31'd0, bus.din_ready}, 32'd1);

    // Back-to-back stream 0xFF 0x00 0x81
    rr0 = rdy_rise; rf0 = rdy_fall;
    feed_q.push_back(8'hFF);
    feed_q.push_back(8'h00);
    feed_q.push_back(8'h81);
    wait_captured();
    sector_words = {8'hFF, 8'h00, 8'h81};
    p0 = pulse_cnt;
    run_sector(PRE, 1'b1, 50);
    chk("stream_pulses", pulse_cnt - p0, 67);
    chk("stream_underrun", {31'd0, underrun}, 32'd0);
    chk("stream_rdy_falls", rdy_fall - rf0, 3);
    chk("stream_rdy_rises", rdy_rise - rr0, 3);
    chk("stream_feed_empty", feed_q.size(), 0);

    // Starved data phase: two zero words, underrun set
    sector_words = {8'h00, 8'h00};
    p0 = pulse_cnt;
    run_sector(PRE, 1'b1, 43);
    chk("underrun_pulses", pulse_cnt - p0, 49);
    chk("underrun_set", {31'd0, underrun}, 32'd1);

    // Preamble truncated at cell 5: 6 clock pulses, no post cell
    sector_words = {};
    p0 = pulse_cnt; b0 = busy_cnt;
    run_sector(6, 1'b0, 5);
    chk("trunc_pulses", pulse_cnt - p0, 6);
    chk("trunc_busy_cycles", busy_cnt - b0, 120);
    chk("trunc_underrun", {31'd0, underrun}, 32'd0);

    // Reset in the middle of a data pulse
    feed_q.push_back(8'hFF);
    wait_captured();
    @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    repeat (CELL * (PRE + 1) + OFF + 1) @(posedge clk);
    #2;
    chk("pre_reset_data_pulse", {31'd0, dsk}, 32'd1);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_abort_dsk", {31'd0, dsk}, 32'd0);
    chk("reset_abort_busy", {31'd0, busy}, 32'd0);
    chk("reset_abort_din_ready", {31'd0, bus.din_ready}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) exp_q.push_back(2'b00);
    repeat (6) @(negedge clk);

    // Restart after reset: full preamble again
    feed_q.push_back(8'h3C);
    wait_captured();
    sector_words = {8'h3C};
    p0 = pulse_cnt; b0 = busy_cnt;
    run_sector(PRE, 1'b1, 35);
    chk("restart_pulses", pulse_cnt - p0, 45);
    chk("restart_busy_cycles", busy_cnt - b0, 820);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
